triangle_unpacker: RTL and testbench



---
 rtl/triangle_unpacker.sv | 173 +++++++++++++++++
 tb/tb_triangle_unpacker.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_unpacker.sv
// -----------------------------------------------------------------------------
// triangle_unpacker
//
// Takes 384-bit triangle words from the triangle FIFO over an AXI-stream
// slave port. Each word is split into three vertices, and those vertices are
// sent one at a time on a valid/ready vertex stream. This block is the only
// place that knows how a triangle word is laid out.
//
// Word layout: component c (0=x,1=y,2=z,3=w) of vertex v sits at
//   s_axis_tdata[(c*NUM_VERTS + v)*DATA_W +: DATA_W]
// Each emitted vertex is packed as {w,z,y,x}, with x in the low DATA_W bits.
//
// Ports:
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   s_axis_tvalid   triangle word valid
//   s_axis_tready   block can accept a triangle word
//   s_axis_tdata    packed triangle word
//   m_vertex_valid  vertex beat valid
//   m_vertex_ready  downstream accepts the vertex
//   m_vertex_data   vertex {w,z,y,x}
//   m_vertex_idx    vertex index within the triangle (0..2)
//   m_vertex_last   high on the final vertex of a triangle
//   tri_count       number of triangles fully emitted (wraps)
//
// Optional build macro: TRI_UNPACK_SKID_EN
//   When this macro is defined, the block has one extra triangle-sized skid
//   buffer. The next triangle can then be accepted while the current one is
//   still being emitted, which gives 3 cycles per triangle instead of 4.
// -----------------------------------------------------------------------------
module triangle_unpacker #(
  parameter int DATA_W    = 32,
  parameter int NUM_VERTS = 3,
  parameter int NUM_COMPS = 4,
  parameter int CNT_W     = 16
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic [NUM_VERTS*NUM_COMPS*DATA_W-1:0] s_axis_tdata,
  output logic                                 m_vertex_valid,
  input  logic                                 m_vertex_ready,
  output logic [NUM_COMPS*DATA_W-1:0]          m_vertex_data,
  output logic [1:0]                           m_vertex_idx,
  output logic                                 m_vertex_last,
  output logic [CNT_W-1:0]                     tri_count
);

  localparam int TRI_W  = NUM_VERTS * NUM_COMPS * DATA_W;
  localparam int VERT_W = NUM_COMPS * DATA_W;
  localparam logic [1:0] LAST_IDX = 2'(NUM_VERTS - 1);

  // ST_RESET holds tready low until the first clock edge after reset is released.
  typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_EMIT} state_t;

  state_t             state, state_next;
  logic [TRI_W-1:0]   hold_buf, hold_next;
  logic [1:0]         vidx, vidx_next;
  logic [CNT_W-1:0]   count, count_next;
  logic               s_accept;
  logic               m_fire;
  logic               emitting;
  logic               last_fire;
  logic [VERT_W-1:0]  vertex;

  assign emitting = (state == ST_EMIT);

`ifdef TRI_UNPACK_SKID_EN
  logic [TRI_W-1:0] skid_buf, skid_next;
  logic             skid_full, skid_full_next;

  assign s_axis_tready = ((state == ST_IDLE) || (state == ST_EMIT)) && !skid_full;
`else
  assign s_axis_tready = (state == ST_IDLE);
`endif

  assign s_accept  = s_axis_tvalid && s_axis_tready;
  assign m_fire    = emitting && m_vertex_ready;
  assign last_fire = m_fire && (vidx == LAST_IDX);

  // Gather the components of the current vertex from the interleaved word.
  always_comb begin
    vertex = '0;
    for (int c = 0; c < NUM_COMPS; c++) begin
      vertex[c*DATA_W +: DATA_W] = hold_buf[(c*NUM_VERTS + int'(vidx))*DATA_W +: DATA_W];
    end
  end

  // All outputs come only from registers, so they are forced to zero outside EMIT.
  assign m_vertex_valid = emitting;
  assign m_vertex_data  = emitting ? vertex : '0;
  assign m_vertex_idx   = emitting ? vidx : 2'd0;
  assign m_vertex_last  = emitting && (vidx == LAST_IDX);
  assign tri_count      = count;

  // Next-state logic. The holding buffer changes only when a new triangle
  // starts, so the output beat stays stable while downstream stalls.
  always_comb begin
    state_next = state;
    hold_next  = hold_buf;
    vidx_next  = vidx;
    count_next = count;
`ifdef TRI_UNPACK_SKID_EN
    skid_next      = skid_buf;
    skid_full_next = skid_full;
`endif
    case (state)
      ST_RESET: state_next = ST_IDLE;
      ST_IDLE: begin
        if (s_accept) begin
          hold_next  = s_axis_tdata;
          vidx_next  = 2'd0;
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (m_fire && !last_fire) begin
          vidx_next = vidx + 2'd1;
        end
        if (last_fire) begin
          count_next = count + CNT_W'(1);
          state_next = ST_IDLE;
`ifdef TRI_UNPACK_SKID_EN
          // Start the next triangle straight away if one is ready, so no
          // idle cycle is inserted between triangles.
          if (skid_full) begin
            hold_next      = skid_buf;
            skid_full_next = 1'b0;
            vidx_next      = 2'd0;
            state_next     = ST_EMIT;
          end else if (s_accept) begin
            hold_next  = s_axis_tdata;
            vidx_next  = 2'd0;
            state_next = ST_EMIT;
          end
`endif
        end
`ifdef TRI_UNPACK_SKID_EN
        if (s_accept && !last_fire) begin
          skid_next      = s_axis_tdata;
          skid_full_next = 1'b1;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State registers. Reset throws away any triangle that is partly emitted.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= ST_RESET;
      hold_buf <= '0;
      vidx     <= 2'd0;
      count    <= '0;
`ifdef TRI_UNPACK_SKID_EN
      skid_buf  <= '0;
      skid_full <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      hold_buf <= hold_next;
      vidx     <= vidx_next;
      count    <= count_next;
`ifdef TRI_UNPACK_SKID_EN
      skid_buf  <= skid_next;
      skid_full <= skid_full_next;
`endif
    end
  end

endmodule

// File: tb/tb_triangle_unpacker.sv
// -----------------------------------------------------------------------------
// tb_triangle_unpacker
//
// Self-checking bench for triangle_unpacker. A transaction-level reference
// model is kept here. Each accepted triangle word pushes its three expected
// vertices onto a queue. Each vertex handshake pops one entry and compares it.
// The expected triangle count is updated from the popped beats.
// A second instance, built with a narrow counter, tests the wrap-around.
// The main instance's behaviour depends on whether TRI_UNPACK_SKID_EN is defined.
// -----------------------------------------------------------------------------
module tb_triangle_unpacker;

  localparam int TW = 384;
  localparam int VW = 128;
  localparam int WRAP_W = 5;
  localparam int WRAP_TRIS = (1 << WRAP_W) + 1;

  logic           clk_in = 1'b0;
  logic           rst_n_in;
  logic           s_tvalid;
  logic           s_tready;
  logic [TW-1:0]  s_tdata;
  logic           m_valid;
  logic           m_ready;
  logic [VW-1:0]  m_data;
  logic [1:0]     m_idx;
  logic           m_last;
  logic [15:0]    tri_count;

  logic              w_valid;
  logic              w_tready;
  logic [TW-1:0]     w_data;
  logic              w_mvalid;
  logic [VW-1:0]     w_mdata;
  logic [1:0]        w_midx;
  logic              w_mlast;
  logic [WRAP_W-1:0] w_count;

  always #5 clk_in = ~clk_in;

  triangle_unpacker dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .m_vertex_valid(m_valid),
    .m_vertex_ready(m_ready),
    .m_vertex_data (m_data),
    .m_vertex_idx  (m_idx),
    .m_vertex_last (m_last),
    .tri_count     (tri_count)
  );

  triangle_unpacker #(.CNT_W(WRAP_W)) dut_wrap (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .s_axis_tvalid (w_valid),
    .s_axis_tready (w_tready),
    .s_axis_tdata  (w_data),
    .m_vertex_valid(w_mvalid),
    .m_vertex_ready(1'b1),
    .m_vertex_data (w_mdata),
    .m_vertex_idx  (w_midx),
    .m_vertex_last (w_mlast),
    .tri_count     (w_count)
  );

  typedef struct packed {
    logic [VW-1:0] data;
    logic [1:0]    idx;
    logic          last;
  } beat_t;

  beat_t       expQ[$];
  logic [15:0] expTri;
  logic        heldValid;
  beat_t       heldBeat;
  int          errors = 0;
  int          checks = 0;
  int          acceptCount = 0;
  int          beatCount = 0;

  // Vertex v taken from a triangle word, using the layout rule directly.
  function automatic logic [VW-1:0] vertexOf(input logic [TW-1:0] w, input int v);
    logic [VW-1:0] r;
    for (int c = 0; c < 4; c++) r[c*32 +: 32] = w[(c*3 + v)*32 +: 32];
    return r;
  endfunction

  function automatic logic [TW-1:0] patternTri();
    logic [TW-1:0] w;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 4; c++) w[(c*3 + v)*32 +: 32] = 32'(v*16 + c);
    return w;
  endfunction

  function automatic logic [TW-1:0] randTri();
    logic [TW-1:0] w;
    for (int i = 0; i < 12; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, score any handshakes, then advance the clock.
  task automatic applyStimulus(input logic valid, input logic [TW-1:0] data, input logic ready);
    logic  sAcc, mAcc;
    beat_t b;
    s_tvalid = valid;
    s_tdata  = data;
    m_ready  = ready;
    #1;
    sAcc = s_tvalid && s_tready;
    mAcc = m_valid && m_ready;
    if (heldValid) begin
      checkOutput("stall_valid", 128'(m_valid), 128'(1'b1));
      checkOutput("stall_data", m_data, heldBeat.data);
      checkOutput("stall_idx", 128'(m_idx), 128'(heldBeat.idx));
      checkOutput("stall_last", 128'(m_last), 128'(heldBeat.last));
    end
    if (mAcc) begin
      checkOutput("beat_expected", 128'(expQ.size() != 0), 128'(1'b1));
      if (expQ.size() != 0) begin
        b = expQ.pop_front();
        checkOutput("beat_data", m_data, b.data);
        checkOutput("beat_idx", 128'(m_idx), 128'(b.idx));
        checkOutput("beat_last", 128'(m_last), 128'(b.last));
        if (b.last) expTri = expTri + 16'd1;
      end
      beatCount++;
    end
    if (sAcc) begin
      for (int v = 0; v < 3; v++) begin
        b.data = vertexOf(data, v);
        b.idx  = 2'(v);
        b.last = (v == 2);
        expQ.push_back(b);
      end
      acceptCount++;
    end
    heldValid     = m_valid && !m_ready;
    heldBeat.data = m_data;
    heldBeat.idx  = m_idx;
    heldBeat.last = m_last;
    @(posedge clk_in);
    #1;
    checkOutput("tri_count", 128'(tri_count), 128'(expTri));
  endtask

  task automatic flushModel();
    expQ.delete();
    expTri    = 16'd0;
    heldValid = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tready"}, 128'(s_tready), 128'(1'b0));
    checkOutput({tag, "_valid"}, 128'(m_valid), 128'(1'b0));
    checkOutput({tag, "_data"}, m_data, 128'(0));
    checkOutput({tag, "_idx"}, 128'(m_idx), 128'(2'd0));
    checkOutput({tag, "_last"}, 128'(m_last), 128'(1'b0));
    checkOutput({tag, "_count"}, 128'(tri_count), 128'(16'd0));
  endtask

  // Abort guard so the bench always ends even if the design wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [TW-1:0] tvc;
    logic [TW-1:0] tA, tB;
    logic [TW-1:0] tR[3];
    logic [8:0]    validBits, readyBits;
    int            base, acc, lastCnt, wAcc;

    tvc       = patternTri();
    rst_n_in  = 1'b0;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    m_ready   = 1'b0;
    w_valid   = 1'b0;
    w_data    = '0;
    flushModel();

    // Reset state and the tready rise after reset is released.
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge clk_in);
    #3;
    checkOutput("reset_tready_hold", 128'(s_tready), 128'(1'b0));
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    checkOutput("tready_after_reset", 128'(s_tready), 128'(1'b1));

    // Single pattern triangle with ready held high.
    applyStimulus(1'b1, tvc, 1'b1);
    checkOutput("t1_valid0", 128'(m_valid), 128'(1'b1));
    checkOutput("t1_data0", m_data, 128'h00000003_00000002_00000001_00000000);
    checkOutput("t1_idx0", 128'(m_idx), 128'(2'd0));
    checkOutput("t1_last0", 128'(m_last), 128'(1'b0));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1_data1", m_data, 128'h00000013_00000012_00000011_00000010);
    checkOutput("t1_idx1", 128'(m_idx), 128'(2'd1));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1_data2", m_data, 128'h00000023_00000022_00000021_00000020);
    checkOutput("t1_idx2", 128'(m_idx), 128'(2'd2));
    checkOutput("t1_last2", 128'(m_last), 128'(1'b1));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1_valid_end", 128'(m_valid), 128'(1'b0));
    checkOutput("t1_count", 128'(tri_count), 128'(16'd1));

    // Same triangle, with downstream ready only on every third cycle.
    base = beatCount;
    applyStimulus(1'b1, tvc, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, (i % 3) == 2);
    checkOutput("t2_beats", 128'(beatCount - base), 128'(3));
    checkOutput("t2_queue_empty", 128'(expQ.size()), 128'(0));
    checkOutput("t2_count", 128'(tri_count), 128'(16'd2));

    // Two triangles back to back, with tvalid held high.
    tA = randTri();
    tB = randTri();
    base = acceptCount;
    validBits = '0;
    readyBits = '0;
    for (int k = 0; k < 9; k++) begin
      acc = acceptCount - base;
      #1;
      validBits[k] = m_valid;
      readyBits[k] = s_tready;
      applyStimulus(acc < 2, (acc == 0) ? tA : tB, 1'b1);
    end
`ifdef TRI_UNPACK_SKID_EN
    checkOutput("b2b_valid", 128'(validBits), 128'(9'h07E));
    checkOutput("b2b_tready", 128'(readyBits), 128'(9'h1F3));
`else
    checkOutput("b2b_valid", 128'(validBits), 128'(9'h0EE));
    checkOutput("b2b_tready", 128'(readyBits), 128'(9'h111));
`endif
    checkOutput("b2b_accepts", 128'(acceptCount - base), 128'(2));
    checkOutput("b2b_queue_empty", 128'(expQ.size()), 128'(0));

    // Reset right after the idx 0 beat; the remaining beats must be dropped.
    applyStimulus(1'b1, randTri(), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mid_idx1", 128'(m_idx), 128'(2'd1));
    rst_n_in = 1'b0;
    #1;
    checkAllZero("mid_reset");
    flushModel();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    checkOutput("mid_tready", 128'(s_tready), 128'(1'b1));
    applyStimulus(1'b1, tvc, 1'b1);
    checkOutput("mid_restart_idx", 128'(m_idx), 128'(2'd0));
    checkOutput("mid_restart_data", m_data, 128'h00000003_00000002_00000001_00000000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mid_count", 128'(tri_count), 128'(16'd1));

    // Fill the skid buffer: ready held low while three triangles are offered.
    for (int i = 0; i < 3; i++) tR[i] = randTri();
    base = acceptCount;
    for (int k = 0; k < 6; k++) begin
      acc = acceptCount - base;
      applyStimulus(acc < 3, tR[(acc < 3) ? acc : 2], 1'b0);
    end
`ifdef TRI_UNPACK_SKID_EN
    checkOutput("skid_accepts", 128'(acceptCount - base), 128'(2));
`else
    checkOutput("skid_accepts", 128'(acceptCount - base), 128'(1));
`endif
    checkOutput("skid_tready", 128'(s_tready), 128'(1'b0));
    for (int k = 0; k < 60; k++) begin
      acc = acceptCount - base;
      if (acc == 3 && expQ.size() == 0 && !m_valid) break;
      applyStimulus(acc < 3, tR[(acc < 3) ? acc : 2], 1'b1);
    end
    checkOutput("skid_drain_accepts", 128'(acceptCount - base), 128'(3));
    checkOutput("skid_drain_empty", 128'(expQ.size()), 128'(0));

    // Random traffic on both sides.
    for (int k = 0; k < 400; k++) applyStimulus(1'($urandom % 2), randTri(), ($urandom % 4) != 0);
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rand_queue_empty", 128'(expQ.size()), 128'(0));
    checkOutput("rand_valid_idle", 128'(m_valid), 128'(1'b0));

    // Counter wrap on the narrow-counter instance.
    wAcc = 0;
    lastCnt = 0;
    for (int k = 0; k < WRAP_TRIS*4 + 20; k++) begin
      w_valid = (wAcc < WRAP_TRIS);
      w_data  = randTri();
      #1;
      if (w_valid && w_tready) wAcc++;
      if (w_mvalid && w_mlast) lastCnt++;
      @(posedge clk_in);
      #1;
      if (lastCnt == WRAP_TRIS && !w_mvalid) break;
    end
    w_valid = 1'b0;
    checkOutput("wrap_last_count", 128'(lastCnt), 128'(WRAP_TRIS));
    checkOutput("wrap_tri_count", 128'(w_count), 128'(WRAP_TRIS % (1 << WRAP_W)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
